// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared constants and helpers for the note-display VGA controller.
//   - raster timing (visible / front porch / sync / back porch, both axes)
//   - 9-bit colour constants {R[2:0],G[2:0],B[2:0]}
//   - staff, ledger, note-head and stem geometry
//   - note_row(): maps an ASCII note code to the head's centre row + valid flag
// ---------------------------------------------------------------------------
package display_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int H_FP     = 16;
  localparam int H_SYNC_W = 96;
  localparam int H_BP     = 48;

  // Vertical timing, in lines.
  localparam int V_FP     = 12;
  localparam int V_SYNC_W = 2;
  localparam int V_BP     = 35;

  // Colours.
  localparam logic [8:0] COL_BLACK = 9'h000;
  localparam logic [8:0] COL_WHITE = 9'h1FF;
  localparam logic [8:0] COL_RED   = 9'b111_000_000;

  // Staff: five 2-px lines, 20 rows apart, starting at row 160.
  localparam int         STAFF_LINES = 5;
  localparam int         STAFF_PITCH = 20;
  localparam int         STAFF_Y0    = 160;
  localparam logic [9:0] LINE_THICK  = 10'd2;
  localparam logic [9:0] STAFF_X0    = 10'd64;
  localparam logic [9:0] STAFF_X1    = 10'd575;

  // Ledger line below the staff, drawn for middle C only.
  localparam logic [9:0] LEDGER_Y  = 10'd260;
  localparam logic [9:0] LEDGER_X0 = 10'd304;
  localparam logic [9:0] LEDGER_X1 = 10'd336;

  // Note head: filled rectangle centred on the note row.
  localparam logic [9:0] HEAD_X0   = 10'd312;
  localparam logic [9:0] HEAD_X1   = 10'd328;
  localparam logic [9:0] HEAD_HALF = 10'd6;

  // Optional stem, rising from the head centre on its right edge.
  localparam logic [9:0] STEM_X0  = 10'd327;
  localparam logic [9:0] STEM_X1  = 10'd328;
  localparam logic [9:0] STEM_LEN = 10'd40;

  // ASCII note codes accepted from the key/note decoder.
  typedef enum logic [7:0] {
    NOTE_A = 8'h41,
    NOTE_B = 8'h42,
    NOTE_C = 8'h43,
    NOTE_D = 8'h44,
    NOTE_E = 8'h45,
    NOTE_F = 8'h46,
    NOTE_G = 8'h47
  } note_code_e;

  typedef struct packed {
    logic       valid;
    logic [9:0] ny;
  } note_t;

  // Each step up the scale moves the head 10 rows higher on screen.
  function automatic note_t note_row(input logic [7:0] code);
    note_t n;
    n.valid = 1'b1;
    case (code)
      NOTE_C:  n.ny = 10'd260;
      NOTE_D:  n.ny = 10'd250;
      NOTE_E:  n.ny = 10'd240;
      NOTE_F:  n.ny = 10'd230;
      NOTE_G:  n.ny = 10'd220;
      NOTE_A:  n.ny = 10'd210;
      NOTE_B:  n.ny = 10'd200;
      default: begin
        n.valid = 1'b0;
        n.ny    = '0;
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/disp_timing.sv
// ---------------------------------------------------------------------------
// disp_timing
// Raster counters and sync/enable generation.
//   pxlclk      in   pixel clock
//   reset       in   asynchronous, active-low
//   hc, vc      out  live column / line counters (0..H_TOTAL-1, 0..V_TOTAL-1)
//   H_SYNC      out  horizontal sync, active low   (registered)
//   V_SYNC      out  vertical sync, active high    (registered)
//   display_en  out  visible-area flag             (registered)
// H_SYNC/V_SYNC/display_en are decoded from the hc/vc value present before
// each edge, so they line up with pixel registers in the parent that load
// from that same hc/vc on that same edge.
// ---------------------------------------------------------------------------
module disp_timing
  import display_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int H_TOTAL   = 800,
  parameter int V_VISIBLE = 400,
  parameter int V_TOTAL   = 449
) (
  input  logic       pxlclk,
  input  logic       reset,
  output logic       H_SYNC,
  output logic       V_SYNC,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       display_en
);

  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  // Sync windows are [start, end): start after the front porch.
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC_W);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC_W);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge hc/vc, keeping sync, enable and counters consistent.
  always_ff @(posedge pxlclk or negedge reset) begin
    if (!reset) begin
      hc         <= '0;
      vc         <= '0;
      H_SYNC     <= 1'b1;
      V_SYNC     <= 1'b0;
      display_en <= 1'b0;
    end else begin
      H_SYNC     <= !((hc >= HS_START) && (hc < HS_END));
      V_SYNC     <= (vc >= VS_START) && (vc < VS_END);
      display_en <= (hc < H_VIS) && (vc < V_VIS);

      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

endmodule

// File: rtl/display_controller.sv
// ---------------------------------------------------------------------------
// display_controller
// VGA note display: white five-line staff on black with a red note head at
// the row selected by the latched note code (ledger line added for C).
//   pxlclk      in   pixel clock (25.175 MHz nominal)
//   reset       in   asynchronous, active-low
//   character   in   ASCII note code 'A'..'G'; anything else draws no note
//   H_SYNC      out  horizontal sync, active low
//   V_SYNC      out  vertical sync, active high
//   RGB         out  pixel colour {R[2:0],G[2:0],B[2:0]}, 0 when blanked
//   display_en  out  high while (px,py) is visible
//   px, py      out  column / line of the pixel currently on RGB
// Build option: define DISP_NOTE_STEM_EN to add a red stem above the head.
// ---------------------------------------------------------------------------
module display_controller
  import display_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int H_TOTAL   = 800,
  parameter int V_VISIBLE = 400,
  parameter int V_TOTAL   = 449
) (
  input  logic       pxlclk,
  input  logic       reset,
  input  logic [7:0] character,
  output logic       H_SYNC,
  output logic       V_SYNC,
  output logic [8:0] RGB,
  output logic       display_en,
  output logic [9:0] px,
  output logic [9:0] py
);

  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic [9:0] hc;
  logic [9:0] vc;
  logic [7:0] note_code;
  note_t      note;
  logic       pixel_visible;
  logic       staff_row;
  logic       staff_hit;
  logic       ledger_hit;
  logic       head_hit;
  logic       red_hit;
  logic [8:0] colour;

  disp_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_TOTAL   (H_TOTAL),
    .V_VISIBLE (V_VISIBLE),
    .V_TOTAL   (V_TOTAL)
  ) u_timing (
    .pxlclk     (pxlclk),
    .reset      (reset),
    .H_SYNC     (H_SYNC),
    .V_SYNC     (V_SYNC),
    .hc         (hc),
    .vc         (vc),
    .display_en (display_en)
  );

  // Sample the note code only on the last pixel of the frame so a whole
  // frame is always drawn from one code, whatever the decoder does meanwhile.
  always_ff @(posedge pxlclk or negedge reset) begin
    if (!reset) begin
      note_code <= '0;
    end else if ((hc == H_LAST) && (vc == V_LAST)) begin
      note_code <= character;
    end
  end

  assign note          = note_row(note_code);
  assign pixel_visible = (hc < H_VIS) && (vc < V_VIS);

  // NOTE: combinational blocks assign a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    staff_row = 1'b0;
    for (int i = 0; i < STAFF_LINES; i++) begin
      if ((vc >= 10'(STAFF_Y0 + i * STAFF_PITCH)) &&
          (vc <  10'(STAFF_Y0 + i * STAFF_PITCH) + LINE_THICK)) begin
        staff_row = 1'b1;
      end
    end
  end

  assign staff_hit  = staff_row && (hc >= STAFF_X0) && (hc <= STAFF_X1);

  assign ledger_hit = (note_code == NOTE_C) &&
                      (vc >= LEDGER_Y) && (vc < LEDGER_Y + LINE_THICK) &&
                      (hc >= LEDGER_X0) && (hc <= LEDGER_X1);

  assign head_hit   = note.valid &&
                      (hc >= HEAD_X0) && (hc <= HEAD_X1) &&
                      (vc >= note.ny - HEAD_HALF) && (vc <= note.ny + HEAD_HALF);

`ifdef DISP_NOTE_STEM_EN
  logic stem_hit;
  assign stem_hit = note.valid &&
                    (hc >= STEM_X0) && (hc <= STEM_X1) &&
                    (vc >= note.ny - STEM_LEN) && (vc <= note.ny);
  assign red_hit  = head_hit || stem_hit;
`else
  assign red_hit  = head_hit;
`endif

  // Note (red) wins over staff/ledger (white), which win over background.
  always_comb begin
    colour = COL_BLACK;
    if (!pixel_visible) begin
      colour = COL_BLACK;
    end else if (red_hit) begin
      colour = COL_RED;
    end else if (staff_hit || ledger_hit) begin
      colour = COL_WHITE;
    end
  end

  // Loaded from the same hc/vc that disp_timing decodes on this edge, so
  // RGB/px/py/sync/enable always describe one and the same pixel.
  always_ff @(posedge pxlclk or negedge reset) begin
    if (!reset) begin
      px  <= '0;
      py  <= '0;
      RGB <= COL_BLACK;
    end else begin
      px  <= hc;
      py  <= vc;
      RGB <= colour;
    end
  end

endmodule

// File: tb/tb_display_controller.sv
// ---------------------------------------------------------------------------
// tb_display_controller
// Self-checking bench: every output pixel is compared against a raster model
// built from plain arithmetic on a running pixel index; a table of spot
// pixels, sync-timing measurements and a mid-line reset sequence add
// targeted checks.
// ---------------------------------------------------------------------------
module tb_display_controller;

  localparam int HT    = 800;
  localparam int VT    = 449;
  localparam int FRAME = HT * VT;

  logic       pxlclk = 1'b0;
  logic       reset  = 1'b0;
  logic [7:0] character = 8'h00;
  logic       H_SYNC;
  logic       V_SYNC;
  logic [8:0] RGB;
  logic       display_en;
  logic [9:0] px;
  logic [9:0] py;

  always #20 pxlclk = ~pxlclk;

  display_controller dut (
    .pxlclk     (pxlclk),
    .reset      (reset),
    .character  (character),
    .H_SYNC     (H_SYNC),
    .V_SYNC     (V_SYNC),
    .RGB        (RGB),
    .display_en (display_en),
    .px         (px),
    .py         (py)
  );

  // ---------------- bookkeeping ----------------
  int total  = 0;
  int failed = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_ny(input logic [7:0] code);
    case (code)
      8'h43:   return 260;  // C
      8'h44:   return 250;  // D
      8'h45:   return 240;  // E
      8'h46:   return 230;  // F
      8'h47:   return 220;  // G
      8'h41:   return 210;  // A
      8'h42:   return 200;  // B
      default: return -1;
    endcase
  endfunction

  function automatic logic [8:0] model_rgb(input int x, input int y,
                                           input logic [7:0] code);
    int ny;
    ny = model_ny(code);
    if (!(x < 640 && y < 400)) return 9'h000;
    if (ny >= 0 && x >= 312 && x <= 328 && y >= ny - 6 && y <= ny + 6)
      return 9'h1C0;
`ifdef DISP_NOTE_STEM_EN
    if (ny >= 0 && x >= 327 && x <= 328 && y >= ny - 40 && y <= ny)
      return 9'h1C0;
`endif
    if (code == 8'h43 && y >= 260 && y <= 261 && x >= 304 && x <= 336)
      return 9'h1FF;
    if (x >= 64 && x <= 575 && y >= 160 && y <= 241 && ((y - 160) % 20) < 2)
      return 9'h1FF;
    return 9'h000;
  endfunction

  // ---------------- spot-pixel table ----------------
  typedef struct {
    logic [7:0] code;
    int         x;
    int         y;
    logic [8:0] rgb;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  int   hits [NV];

  // ---------------- running model state ----------------
  int         n;           // index of the pixel the DUT should be showing
  int         cyc;
  logic [7:0] frame_code;  // code the current frame is drawn with
  logic [7:0] next_code;   // code captured at the last frame boundary
  int mm_rgb, mm_pos, mm_sync, mm_en, blank_bad;

  // sync measurements taken from DUT outputs
  int   last_px0, line_period, hs_fall, hs_off, hs_len;
  int   vs_rise, vs_rise_py, vs_len, fs_last, frame_period;
  logic prev_hs, prev_vs;

  task automatic step();
    int         x, y;
    logic [8:0] e_rgb;
    @(posedge pxlclk);
    #1;
    cyc++;
    x = n % HT;
    y = (n / HT) % VT;
    if (x == 0 && y == 0 && n > 0) frame_code = next_code;
    e_rgb = model_rgb(x, y, frame_code);

    if (RGB !== e_rgb) mm_rgb++;
    if (px !== 10'(x) || py !== 10'(y)) mm_pos++;
    if (H_SYNC !== !(x >= 656 && x < 752) || V_SYNC !== (y >= 412 && y < 414))
      mm_sync++;
    if (display_en !== (x < 640 && y < 400)) mm_en++;
    if (!(x < 640 && y < 400) && (display_en !== 1'b0 || RGB !== 9'h000))
      blank_bad++;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].code == frame_code && vecs[i].x == x && vecs[i].y == y) begin
        hits[i]++;
        check($sformatf("pixel code=%02h (%0d,%0d) RGB", vecs[i].code, x, y),
              int'(RGB), int'(vecs[i].rgb));
      end
    end

    if (px == 10'd0) begin
      if (last_px0 >= 0) line_period = cyc - last_px0;
      last_px0 = cyc;
    end
    if (prev_hs && !H_SYNC) begin
      hs_fall = cyc;
      hs_off  = cyc - last_px0;
    end
    if (!prev_hs && H_SYNC && hs_fall >= 0) hs_len = cyc - hs_fall;
    if (!prev_vs && V_SYNC) begin
      vs_rise    = cyc;
      vs_rise_py = int'(py);
    end
    if (prev_vs && !V_SYNC && vs_rise >= 0) vs_len = cyc - vs_rise;
    if (px == 10'd0 && py == 10'd0) begin
      if (fs_last >= 0) frame_period = cyc - fs_last;
      fs_last = cyc;
    end
    prev_hs = H_SYNC;
    prev_vs = V_SYNC;

    // The DUT samples 'character' on the edge that shows the frame's last pixel.
    if (x == HT - 1 && y == VT - 1) next_code = character;
    n++;
  endtask

  task automatic check_frame(input string tag);
    check({tag, " RGB mismatches"}, mm_rgb, 0);
    check({tag, " px/py mismatches"}, mm_pos, 0);
    check({tag, " sync mismatches"}, mm_sync, 0);
    check({tag, " display_en mismatches"}, mm_en, 0);
    check({tag, " blanking violations"}, blank_bad, 0);
    mm_rgb = 0; mm_pos = 0; mm_sync = 0; mm_en = 0; blank_bad = 0;
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] letters [7];
    letters = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    if ($urandom_range(0, 2) == 0) return letters[$urandom_range(0, 6)];
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " px"}, int'(px), 0);
    check({tag, " py"}, int'(py), 0);
    check({tag, " display_en"}, int'(display_en), 0);
    check({tag, " RGB"}, int'(RGB), 0);
    check({tag, " H_SYNC"}, int'(H_SYNC), 1);
    check({tag, " V_SYNC"}, int'(V_SYNC), 0);
  endtask

  initial begin
    int guard;
    vecs[0]  = '{8'h00, 100, 160, 9'h1FF};
    vecs[1]  = '{8'h00, 100, 161, 9'h1FF};
    vecs[2]  = '{8'h00, 100, 162, 9'h000};
    vecs[3]  = '{8'h00,  63, 160, 9'h000};
    vecs[4]  = '{8'h00, 575, 241, 9'h1FF};
    vecs[5]  = '{8'h00, 576, 241, 9'h000};
    vecs[6]  = '{8'h00, 320, 220, 9'h1FF};
    vecs[7]  = '{8'h43, 320, 260, 9'h1C0};
    vecs[8]  = '{8'h43, 304, 261, 9'h1FF};
    vecs[9]  = '{8'h43, 300, 260, 9'h000};
    vecs[10] = '{8'h43, 336, 260, 9'h1FF};
    vecs[11] = '{8'h43, 337, 260, 9'h000};
    vecs[12] = '{8'h43, 312, 254, 9'h1C0};
    vecs[13] = '{8'h43, 320, 267, 9'h000};
    vecs[14] = '{8'h47, 320, 220, 9'h1C0};
    vecs[15] = '{8'h47, 200, 220, 9'h1FF};
    vecs[16] = '{8'h47, 320, 260, 9'h000};
    vecs[17] = '{8'h47, 329, 220, 9'h1FF};
    for (int i = 0; i < NV; i++) hits[i] = 0;

    n = 0; cyc = 0; frame_code = 8'h00; next_code = 8'h00;
    mm_rgb = 0; mm_pos = 0; mm_sync = 0; mm_en = 0; blank_bad = 0;
    last_px0 = -1; line_period = -1; hs_fall = -1; hs_off = -1; hs_len = -1;
    vs_rise = -1; vs_rise_py = -1; vs_len = -1; fs_last = -1; frame_period = -1;
    prev_hs = 1'b1; prev_vs = 1'b0;

    // Reset state.
    repeat (3) @(posedge pxlclk);
    #1;
    check_reset_values("in reset");
    @(negedge pxlclk);
    reset = 1'b1;

    // Frame 0: no note; the code for frame 1 arrives late in frame 0.
    step();
    check("first pixel px", int'(px), 0);
    check("first pixel py", int'(py), 0);
    check("first pixel display_en", int'(display_en), 1);
    while (n < 300 * HT) step();
    character = 8'h43;
    while (n < FRAME + 4) step();
    check_frame("frame0");
    check("H_SYNC offset from px=0", hs_off, 656);
    check("H_SYNC low width", hs_len, 96);
    check("line period", line_period, 800);
    check("V_SYNC rise at py", vs_rise_py, 412);
    check("V_SYNC high width", vs_len, 1600);
    check("frame period", frame_period, FRAME);

    // Frame 1: drawn with C while the input churns from row 100 onward.
    while (n < FRAME + 100 * HT) step();
    character = 8'h47;
    while (n < FRAME + 448 * HT) begin
      step();
      character = rand_code();
    end
    character = 8'h47;
    while (n < 2 * FRAME) step();
    check_frame("frame1");

    // Frame 2: drawn with G, random churn after row 100.
    while (n < 2 * FRAME + 100 * HT) step();
    while (n < 2 * FRAME + 280 * HT) begin
      step();
      character = rand_code();
    end
    check_frame("frame2");

    // Mid-line reset at px=300.
    character = 8'h43;
    guard = 0;
    while (px != 10'd300 && guard < 2 * HT) begin
      step();
      guard++;
    end
    check("reached px=300 before reset", int'(px), 300);
    reset = 1'b0;
    #1;
    check_reset_values("async reset");
    repeat (2) @(posedge pxlclk);
    #1;
    check_reset_values("held reset");
    @(negedge pxlclk);
    reset = 1'b1;
    n = 0; frame_code = 8'h00; next_code = 8'h00;
    step();
    check("restart px", int'(px), 0);
    check("restart py", int'(py), 0);
    check("restart display_en", int'(display_en), 1);
    while (n < 3 * HT) step();
    check_frame("after reset");

    for (int i = 0; i < NV; i++)
      check($sformatf("table entry %0d visited", i), int'(hits[i] > 0), 1);

    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end

endmodule

// File: doc/display_controller.md
# display_controller

Pixel-clock-driven VGA display controller for the synth's note display. It generates 640×400 timing in an 800×449 raster, with sync outputs. It draws a white five-line staff (pentagram) on black, plus a red note head at the staff position selected by the `character` code. It sits between the key/note decoder (which supplies `character`) and the board's VGA DAC pins.

## Interface
Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_TOTAL`, 800, pixel clocks per line
- `V_VISIBLE`, 400, active lines per frame
- `V_TOTAL`, 449, lines per frame

Ports:
- `pxlclk`  in  1  pixel clock (25.175 MHz nominal)
- `reset`  in  1  asynchronous, active-low
- `character`  in  8  note code; ASCII `C D E F G A B` (0x43,0x44,0x45,0x46,0x47,0x41,0x42); any other value means no note
- `H_SYNC`  out  1  horizontal sync, active low
- `V_SYNC`  out  1  vertical sync, active high
- `RGB`  out  9  colour {R[2:0],G[2:0],B[2:0]}
- `display_en`  out  1  high while (`px`,`py`) is in the visible area
- `px`  out  10  current column, 0..799
- `py`  out  10  current line, 0..448

## Operation
- **Counters:** internal `hc` runs 0..799. `vc` increments when `hc` wraps 799→0, and `vc` runs 0..448, wrapping 448→0.
- **Sync:** `H_SYNC`=0 for `hc` 656..751, else 1. `V_SYNC`=1 for `vc` 412..413, else 0.
- **Enable:** `display_en` = (`hc`<640) && (`vc`<400).
- **Note latch:** `character` is latched at `hc`=799, `vc`=448, i.e. at the frame boundary. The latched code is used for the entire next frame, so there is no mid-frame tearing.
- **Staff:** five lines, each 2 px thick, spanning x 64..575. They occupy y 160–161, 180–181, 200–201, 220–221 and 240–241.
- **Note row `ny` (head centre):**
  - C=260, D=250, E=240, F=230, G=220, A=210, B=200.
  - Invalid code: no note is drawn.
- **Note head:** filled rectangle, x 312..328, y `ny`−6..`ny`+6, colour 9'b111_000_000.
- **Ledger line:** drawn only for C. It is 2 px thick at y 260–261, x 304..336, colour white.
- **Priority:** note head > ledger/staff (white 9'h1FF) > background black 9'h000.
- **Blanking:** `RGB` = 0 whenever `display_en` = 0.

## Timing
- **Registering:** all outputs (`H_SYNC`, `V_SYNC`, `RGB`, `display_en`, `px`, `py`) are registered from the same counter values, so they are mutually aligned. In any cycle, `RGB` is the colour of pixel (`px`,`py`).
- **Reset values:**
  - Counters = 0.
  - `px`=0, `py`=0, `display_en`=0, `RGB`=0.
  - `H_SYNC`=1, `V_SYNC`=0.
  - Latched character = 0.
- **Start-up:** the first rising edge after reset deassertion presents pixel (0,0) with `display_en`=1. `px` then advances by one per clock.
- **Rates:** line period is 800 clocks; frame period is 359 200 clocks.
- **Mid-operation reset:** immediately forces the reset values and restarts the raster at (0,0).

## Configuration
- **`DISP_NOTE_STEM_EN` defined:** a stem is drawn in colour 9'b111_000_000.
  - It is 2 px wide at x 327..328, covering y `ny`−40..`ny`.
  - It is drawn only when a valid note is latched.
- **`DISP_NOTE_STEM_EN` undefined:** no stem logic; the head alone is drawn.

## Structure
- **Package `display_pkg`:**
  - Timing constants (visible, front porch 16/12, sync 96/2, back porch 48/35).
  - Colour constants.
  - Staff line rows and x extents.
  - Note-head geometry.
  - A function mapping the 8-bit code to `ny` plus a valid flag.
- **Sub-module `disp_timing`:** contains the `hc`/`vc` counters and the sync/enable generation. Ports: `pxlclk`, `reset`, `H_SYNC`, `V_SYNC`, `hc`, `vc`, `display_en`.
- **Top level:** instantiates `disp_timing` and contains the pixel-colour logic and the output registers.

## Test plan
- **Reset release, `character`=0, capture one 640×400 frame:** nonzero only on rows 160,161,180,181,200,201,220,221,240,241 for x 64..575; all other pixels are 0.
- **Sync timing:** `H_SYNC` low for exactly 96 clocks, starting 656 clocks after `px`=0. Line period is 800 clocks. `V_SYNC` high for 1600 clocks, starting at `py`=412. Frame period is 359 200 clocks.
- **`character`=0x43 ('C'):** next frame has `RGB`=9'h1C0 at (320,260), a white ledger line at (304,261), and `RGB`=0 at (300,260).
- **`character`=0x47 ('G'):** (320,220) is red and (200,220) is white. Changing the code mid-frame leaves the current frame unchanged and updates the following frame.
- **Blanking:** at `px` 640..799 or `py` 400..448, `display_en`=0 and `RGB`=0.
- **Reset asserted mid-line at `px`=300:** outputs take their reset values immediately; after release, `px`/`py` restart at 0,0.
